softmax_job_sched: RTL and testbench

Job-level sequencer in front of the softmax core. It accepts softmax job descriptors (start/end address of one vector) into a small FIFO and dispatches them to the core one at a time. For each job it drives the core's init, start, start_addr and end_addr, tracks the core's done window, and reports completion with a job ID and status. A watchdog recovers a hung core by pulsing a core-local reset.

---
 rtl/softmax_job_sched_if.sv | 38 +++
 rtl/softmax_job_sched.sv | 154 +++++++++++++++
 tb/tb_softmax_job_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_job_sched_if.sv
// softmax_job_sched_if: job descriptor, core control and completion signals of the softmax job sequencer
//   job_*     descriptor push handshake (valid/ready + start/end address)
//   sm_*      softmax core control (init/start pulses, held addresses, done level)
//   core_rst  core-local reset pulse from the watchdog
//   cmpl_*    one-cycle completion report (id, status)
//   busy, q_count  sequencer status
// The slave modport is the sequencer; the master modport is its environment.
interface softmax_job_sched_if #(
    parameter int ADDRSIZE = 8,
    parameter int QDEPTH = 4,
    parameter int IDW = 4
);
    logic                      job_valid;
    logic                      job_ready;
    logic [ADDRSIZE-1:0]       job_start_addr;
    logic [ADDRSIZE-1:0]       job_end_addr;
    logic                      sm_init;
    logic                      sm_start;
    logic [ADDRSIZE-1:0]       sm_start_addr;
    logic [ADDRSIZE-1:0]       sm_end_addr;
    logic                      sm_done;
    logic                      core_rst;
    logic                      cmpl_valid;
    logic [IDW-1:0]            cmpl_id;
    logic [1:0]                cmpl_status;
    logic                      busy;
    logic [$clog2(QDEPTH):0]   q_count;
    modport slave (
        input  job_valid, job_start_addr, job_end_addr, sm_done,
        output job_ready, sm_init, sm_start, sm_start_addr, sm_end_addr,
               core_rst, cmpl_valid, cmpl_id, cmpl_status, busy, q_count
    );
    modport master (
        output job_valid, job_start_addr, job_end_addr, sm_done,
        input  job_ready, sm_init, sm_start, sm_start_addr, sm_end_addr,
               core_rst, cmpl_valid, cmpl_id, cmpl_status, busy, q_count
    );
endinterface

// File: rtl/softmax_job_sched.sv
// softmax_job_sched: queues softmax job descriptors and runs them one at a time on the core, with a done-window tracker and watchdog
//   clk, reset  clock and synchronous active-high reset
//   bus         softmax_job_sched_if.slave: job push, core control, completion and status
// All outputs come straight from flops.
module softmax_job_sched #(
    parameter int ADDRSIZE = 8,
    parameter int QDEPTH = 4,
    parameter int IDW = 4,
    parameter int TIMEOUT = 1024
) (
    input logic clk,
    input logic reset,
    softmax_job_sched_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, INIT, START, WAIT, DRAIN, ABORT, CMPL} state_e;

    state_e                  state_q, state_d;
    logic [2*ADDRSIZE-1:0]   mem_q [QDEPTH];
    logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic [IDW-1:0]          nid_q, nid_d, jid_q, jid_d, cid_q, cid_d;
    logic [WW-1:0]           wd_q, wd_d;
    logic                    done_q;
    logic [ADDRSIZE-1:0]     sa_q, sa_d, ea_q, ea_d;
    logic                    init_q, init_d, start_q, start_d, crst_q, crst_d;
    logic                    cv_q, cv_d, busy_q, busy_d;
    logic [1:0]              cst_q, cst_d;
    logic                    push, pop, rise, expire;
    logic [ADDRSIZE-1:0]     hs, he;

    always_comb begin
        push    = bus.job_valid & ready_q;
        pop     = (state_q == IDLE) && (cnt_q != '0);
        hs      = mem_q[rd_q][2*ADDRSIZE-1:ADDRSIZE];
        he      = mem_q[rd_q][ADDRSIZE-1:0];
        // done_q tracks sm_done every cycle, so a level already high on entry to WAIT is not an edge
        rise    = bus.sm_done & ~done_q;
        expire  = wd_q == WW'(TIMEOUT - 1);
        state_d = state_q;
        wd_d    = wd_q;
        sa_d    = sa_q;
        ea_d    = ea_q;
        nid_d   = nid_q;
        jid_d   = jid_q;
        cst_d   = cst_q;
        case (state_q)
            IDLE: if (pop) begin
                sa_d  = hs;
                ea_d  = he;
                jid_d = nid_q;
                nid_d = nid_q + 1'b1;
                state_d = (he >= hs) ? INIT : CMPL;
                cst_d = (he >= hs) ? cst_q : 2'd2;
            end
            INIT:  state_d = START;
            START: begin
                state_d = WAIT;
                wd_d = '0;
            end
            // watchdog expiry wins over a done edge in the same cycle
            WAIT, DRAIN: if (expire) begin
                state_d = ABORT;
                wd_d = '0;
            end else begin
                wd_d = wd_q + 1'b1;
                if (state_q == WAIT && rise) state_d = DRAIN;
                else if (state_q == DRAIN && !bus.sm_done) begin
                    state_d = CMPL;
                    cst_d = 2'd0;
                end
            end
            // wd reused as a two-cycle counter for the core reset pulse
            ABORT: if (wd_q[0]) begin
                state_d = CMPL;
                cst_d = 2'd1;
            end else wd_d = wd_q + 1'b1;
            CMPL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        ready_d = cnt_d != CW'(QDEPTH);
        init_d  = state_d == INIT;
        start_d = state_d == START;
        crst_d  = state_d == ABORT;
        cv_d    = state_d == CMPL;
        cid_d   = cv_d ? jid_d : cid_q;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {bus.job_start_addr, bus.job_end_addr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            nid_q   <= '0;
            jid_q   <= '0;
            cid_q   <= '0;
            wd_q    <= '0;
            done_q  <= 1'b0;
            sa_q    <= '0;
            ea_q    <= '0;
            init_q  <= 1'b0;
            start_q <= 1'b0;
            crst_q  <= 1'b0;
            cv_q    <= 1'b0;
            busy_q  <= 1'b0;
            cst_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            nid_q   <= nid_d;
            jid_q   <= jid_d;
            cid_q   <= cid_d;
            wd_q    <= wd_d;
            done_q  <= bus.sm_done;
            sa_q    <= sa_d;
            ea_q    <= ea_d;
            init_q  <= init_d;
            start_q <= start_d;
            crst_q  <= crst_d;
            cv_q    <= cv_d;
            busy_q  <= busy_d;
            cst_q   <= cst_d;
        end
    end

    assign bus.job_ready     = ready_q;
    assign bus.q_count       = cnt_q;
    assign bus.sm_init       = init_q;
    assign bus.sm_start      = start_q;
    assign bus.sm_start_addr = sa_q;
    assign bus.sm_end_addr   = ea_q;
    assign bus.core_rst      = crst_q;
    assign bus.cmpl_valid    = cv_q;
    assign bus.cmpl_id       = cid_q;
    assign bus.cmpl_status   = cst_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_softmax_job_sched.sv
// tb_softmax_job_sched: directed checks of dispatch timing, FIFO, IDs, bad range, watchdog, stale done and mid-job reset
module tb_softmax_job_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    softmax_job_sched_if #(.ADDRSIZE(8), .QDEPTH(4), .IDW(4)) bus ();
    softmax_job_sched_if #(.ADDRSIZE(8), .QDEPTH(4), .IDW(4)) bt ();

    softmax_job_sched #(.ADDRSIZE(8), .QDEPTH(4), .IDW(4), .TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    softmax_job_sched #(.ADDRSIZE(8), .QDEPTH(4), .IDW(4), .TIMEOUT(16)) dut_t (
        .clk(clk), .reset(reset), .bus(bt)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int init_cnt = 0;
    int cmpl_cnt = 0;
    int k0, b0;

    always @(negedge clk) begin
        if (bus.sm_init) init_cnt++;
        if (bus.cmpl_valid) cmpl_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.job_valid = 1'b0;
        bus.sm_done = 1'b0;
        bt.job_valid = 1'b0;
        bt.sm_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] s, input logic [7:0] e);
        bus.job_valid = 1'b1;
        bus.job_start_addr = s;
        bus.job_end_addr = e;
        for (int k = 0; k < 64 && !bus.job_ready; k++) tick();
        chk("push_ready", bus.job_ready, 1);
        tick();
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_start();
        for (int k = 0; k < 64 && !bus.sm_start; k++) tick();
        chk("start_seen", bus.sm_start, 1);
    endtask

    task automatic wait_cmpl();
        for (int k = 0; k < 16 && !bus.cmpl_valid; k++) tick();
        chk("cmpl_seen", bus.cmpl_valid, 1);
    endtask

    task automatic pulse_done();
        tick();
        bus.sm_done = 1'b1;
        tick();
        bus.sm_done = 1'b0;
    endtask

    initial begin
        bus.job_valid = 1'b0;
        bus.job_start_addr = '0;
        bus.job_end_addr = '0;
        bus.sm_done = 1'b0;
        bt.job_valid = 1'b0;
        bt.job_start_addr = '0;
        bt.job_end_addr = '0;
        bt.sm_done = 1'b0;
        tick();
        tick();
        chk("rst_ready", bus.job_ready, 1);
        chk("rst_qcount", bus.q_count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_init", bus.sm_init, 0);
        chk("rst_cmpl", bus.cmpl_valid, 0);
        chk("rst_core_rst", bus.core_rst, 0);
        chk("rst_sa", bus.sm_start_addr, 0);
        reset = 1'b0;

        // single job, done high cycles 20..22
        bus.job_start_addr = 8'h10;
        bus.job_end_addr = 8'h1F;
        bus.job_valid = 1'b1;
        tick();
        bus.job_valid = 1'b0;
        chk("t1_qcount_c0", bus.q_count, 1);
        chk("t1_init_c0", bus.sm_init, 0);
        tick();
        chk("t1_init_c1", bus.sm_init, 1);
        chk("t1_sa", bus.sm_start_addr, 8'h10);
        chk("t1_ea", bus.sm_end_addr, 8'h1F);
        chk("t1_qcount_c1", bus.q_count, 0);
        chk("t1_busy_c1", bus.busy, 1);
        tick();
        chk("t1_start_c2", bus.sm_start, 1);
        chk("t1_init_c2", bus.sm_init, 0);
        repeat (18) tick();
        bus.sm_done = 1'b1;
        tick();
        tick();
        tick();
        bus.sm_done = 1'b0;
        chk("t1_cmpl_c23", bus.cmpl_valid, 0);
        chk("t1_busy_c23", bus.busy, 1);
        tick();
        chk("t1_cmpl_c24", bus.cmpl_valid, 1);
        chk("t1_id", bus.cmpl_id, 0);
        chk("t1_status", bus.cmpl_status, 0);
        tick();
        chk("t1_cmpl_c25", bus.cmpl_valid, 0);
        chk("t1_busy_c25", bus.busy, 0);
        chk("t1_sa_hold", bus.sm_start_addr, 8'h10);

        // five jobs back to back into a depth-4 FIFO, first one popped immediately
        do_reset();
        b0 = cmpl_cnt;
        for (int i = 0; i < 5; i++) push(8'(16 * i), 8'(16 * i + 15));
        chk("t2_full_qcount", bus.q_count, 4);
        chk("t2_full_ready", bus.job_ready, 0);
        bus.job_valid = 1'b1;
        bus.job_start_addr = 8'hEE;
        bus.job_end_addr = 8'hEF;
        tick();
        tick();
        bus.job_valid = 1'b0;
        chk("t2_full_ignore", bus.q_count, 4);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) wait_start();
            chk("t2_sa", bus.sm_start_addr, 16 * i);
            chk("t2_ea", bus.sm_end_addr, 16 * i + 15);
            pulse_done();
            wait_cmpl();
            chk("t2_id", bus.cmpl_id, i);
            chk("t2_status", bus.cmpl_status, 0);
        end
        tick();
        tick();
        chk("t2_idle", bus.busy, 0);
        chk("t2_empty", bus.q_count, 0);
        chk("t2_cmpl_total", cmpl_cnt - b0, 5);

        // bad range completes straight from IDLE, next job takes the next ID
        do_reset();
        b0 = init_cnt;
        push(8'h20, 8'h1F);
        chk("t3_cmpl_push", bus.cmpl_valid, 0);
        tick();
        chk("t3_cmpl", bus.cmpl_valid, 1);
        chk("t3_status", bus.cmpl_status, 2);
        chk("t3_id", bus.cmpl_id, 0);
        chk("t3_sa", bus.sm_start_addr, 8'h20);
        chk("t3_init", bus.sm_init, 0);
        tick();
        chk("t3_cmpl_end", bus.cmpl_valid, 0);
        chk("t3_busy", bus.busy, 0);
        chk("t3_no_init", init_cnt - b0, 0);
        push(8'h30, 8'h3F);
        wait_start();
        chk("t3_next_sa", bus.sm_start_addr, 8'h30);
        pulse_done();
        wait_cmpl();
        chk("t3_next_id", bus.cmpl_id, 1);
        chk("t3_next_status", bus.cmpl_status, 0);

        // watchdog with TIMEOUT=16
        do_reset();
        bt.job_start_addr = 8'h40;
        bt.job_end_addr = 8'h4F;
        bt.job_valid = 1'b1;
        tick();
        bt.job_start_addr = 8'h50;
        bt.job_end_addr = 8'h5F;
        tick();
        bt.job_valid = 1'b0;
        chk("t4_init", bt.sm_init, 1);
        tick();
        chk("t4_start", bt.sm_start, 1);
        k0 = cyc;
        for (int j = 0; j < 40 && !bt.core_rst; j++) tick();
        chk("t4_rst_delay", cyc - k0, 17);
        chk("t4_rst_1", bt.core_rst, 1);
        tick();
        chk("t4_rst_2", bt.core_rst, 1);
        chk("t4_cmpl_early", bt.cmpl_valid, 0);
        tick();
        chk("t4_rst_off", bt.core_rst, 0);
        chk("t4_cmpl", bt.cmpl_valid, 1);
        chk("t4_status", bt.cmpl_status, 1);
        chk("t4_id", bt.cmpl_id, 0);
        tick();
        chk("t4_gap", bt.sm_init, 0);
        tick();
        chk("t4_next_init", bt.sm_init, 1);
        chk("t4_next_sa", bt.sm_start_addr, 8'h50);
        tick();
        chk("t4_next_start", bt.sm_start, 1);
        repeat (16) tick();
        bt.sm_done = 1'b1;
        tick();
        chk("t4_prio", bt.core_rst, 1);
        bt.sm_done = 1'b0;
        tick();
        tick();
        chk("t4_prio_cmpl", bt.cmpl_valid, 1);
        chk("t4_prio_status", bt.cmpl_status, 1);
        chk("t4_prio_id", bt.cmpl_id, 1);

        // sm_done already high when the job enters WAIT
        do_reset();
        bus.sm_done = 1'b1;
        tick();
        b0 = cmpl_cnt;
        push(8'h60, 8'h6F);
        wait_start();
        repeat (8) tick();
        chk("t5_busy_hi", bus.busy, 1);
        chk("t5_no_cmpl_hi", cmpl_cnt - b0, 0);
        bus.sm_done = 1'b0;
        repeat (3) tick();
        chk("t5_busy_lo", bus.busy, 1);
        chk("t5_no_cmpl_lo", cmpl_cnt - b0, 0);
        pulse_done();
        wait_cmpl();
        chk("t5_id", bus.cmpl_id, 0);
        chk("t5_status", bus.cmpl_status, 0);

        // reset in WAIT with two jobs queued
        do_reset();
        push(8'h80, 8'h8F);
        push(8'h90, 8'h9F);
        push(8'hA0, 8'hAF);
        chk("t6_queued", bus.q_count, 2);
        wait_start();
        tick();
        tick();
        b0 = cmpl_cnt;
        reset = 1'b1;
        tick();
        chk("t6_qcount", bus.q_count, 0);
        chk("t6_ready", bus.job_ready, 1);
        chk("t6_busy", bus.busy, 0);
        chk("t6_cmpl", bus.cmpl_valid, 0);
        chk("t6_init", bus.sm_init, 0);
        chk("t6_sa", bus.sm_start_addr, 0);
        chk("t6_ea", bus.sm_end_addr, 0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("t6_idle", bus.busy, 0);
        chk("t6_no_cmpl", cmpl_cnt - b0, 0);
        push(8'h70, 8'h7F);
        wait_start();
        chk("t6_next_sa", bus.sm_start_addr, 8'h70);
        pulse_done();
        wait_cmpl();
        chk("t6_next_id", bus.cmpl_id, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
